// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding and legal frame settings.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

   localparam int STOP_BITS_MIN = 1;
   localparam int STOP_BITS_MAX = 2;

   function automatic logic stop_bits_legal(input int n);
      return (n >= STOP_BITS_MIN) && (n <= STOP_BITS_MAX);
   endfunction

endpackage

// File: rtl/uart_tx_fsm.sv
// Frame sequencer for the UART transmitter: state register plus next-state decode.
module uart_tx_fsm
   import uart_pkg::*;
(
   input  logic      CLK,
   input  logic      RESET_N,
   input  logic      hold_full,
   input  logic      bit_end,
   input  logic      data_last,
   input  logic      stop_last,
   input  logic      par_en,
   output tx_state_t state,
   output tx_state_t next_state
);

   // Every transition except IDLE->START happens only at the end of a bit period.
   always_comb begin
      next_state = state;
      case (state)
         ST_IDLE:   if (hold_full) next_state = ST_START;
         ST_START:  if (bit_end) next_state = ST_DATA;
         ST_DATA:   if (bit_end && data_last) next_state = par_en ? ST_PARITY : ST_STOP;
         ST_PARITY: if (bit_end) next_state = ST_STOP;
         ST_STOP:   if (bit_end && stop_last) next_state = hold_full ? ST_START : ST_IDLE;
         default:   next_state = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) state <= ST_IDLE;
      else          state <= next_state;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding register, LSB-first shifter, optional parity,
// 1 or 2 stop bits, programmable bit time. TX is driven straight from a flop.
module uart_tx
   import uart_pkg::*;
#(
   parameter int STOP_BITS = 1
) (
   input  logic        CLK,
   input  logic        RESET_N,
   input  logic [15:0] BIT_TIME,
   input  logic        PARITY_EN,
   input  logic        PARITY_ODD,
   input  logic [7:0]  DATA,
   input  logic        EN,
   output logic        READY,
   output logic        IDLE,
   output logic        TX
);

   // Illegal STOP_BITS values fall back to a single stop bit.
   localparam logic [2:0] STOP_LAST = stop_bits_legal(STOP_BITS) ? 3'(STOP_BITS - 1) : 3'd0;

   tx_state_t   state, next_state;
   logic [15:0] bit_time_q, bit_cnt;
   logic [2:0]  data_cnt;
   logic [7:0]  hold_data, shift_q, shift_d;
   logic        hold_full, par_en_q, par_acc, par_d, tx_q, tx_d;
   logic        bit_end, load;

   assign bit_end = (bit_cnt == bit_time_q);
   assign load    = (next_state == ST_START) && (state != ST_START);

   uart_tx_fsm u_fsm (
      .CLK        (CLK),
      .RESET_N    (RESET_N),
      .hold_full  (hold_full),
      .bit_end    (bit_end),
      .data_last  (data_cnt == 3'd7),
      .stop_last  (data_cnt == STOP_LAST),
      .par_en     (par_en_q),
      .state      (state),
      .next_state (next_state)
   );

   // Parity accumulator is seeded with the odd/even select, then folds in each bit as it leaves.
   always_comb begin
      shift_d = shift_q;
      par_d   = par_acc;
      if (load) begin
         shift_d = hold_data;
         par_d   = PARITY_ODD;
      end else if (state == ST_DATA && bit_end) begin
         shift_d = shift_q >> 1;
         par_d   = par_acc ^ shift_q[0];
      end
   end

   // TX is registered from the upcoming state so the line changes on the transition edge.
   always_comb begin
      case (next_state)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = shift_d[0];
         ST_PARITY: tx_d = par_d;
         default:   tx_d = 1'b1;
      endcase
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         tx_q       <= 1'b1;
         shift_q    <= '0;
         par_acc    <= 1'b0;
         hold_data  <= '0;
         hold_full  <= 1'b0;
         bit_time_q <= '0;
         par_en_q   <= 1'b0;
         bit_cnt    <= '0;
         data_cnt   <= '0;
      end else begin
         tx_q    <= tx_d;
         shift_q <= shift_d;
         par_acc <= par_d;

         if (load) begin
            bit_time_q <= BIT_TIME;
            par_en_q   <= PARITY_EN;
         end

         if (load)
            hold_full <= 1'b0;
         else if (EN && !hold_full) begin
            hold_full <= 1'b1;
            hold_data <= DATA;
         end

         bit_cnt <= (state == ST_IDLE || bit_end) ? 16'd0 : bit_cnt + 16'd1;

         // Shared between data bits and stop bits; cleared on every state change.
         if (next_state != state)
            data_cnt <= '0;
         else if (bit_end && (state == ST_DATA || state == ST_STOP))
            data_cnt <= data_cnt + 3'd1;
      end
   end

   assign READY = ~hold_full;
   assign IDLE  = (state == ST_IDLE) && !hold_full;
   assign TX    = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed and randomized bench for uart_tx; expected line waveform is built per cycle from frame bits.
module tb_uart_tx;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [15:0] bit_time;
   logic        par_en, par_odd, en, en2;
   logic [7:0]  data;
   logic        ready, idle, tx, ready2, idle2, tx2;

   int n_cmp  = 0;
   int n_fail = 0;
   bit exp_q[$];

   always #5 clk = ~clk;

   uart_tx #(.STOP_BITS(1)) dut (
      .CLK(clk), .RESET_N(rst_n), .BIT_TIME(bit_time), .PARITY_EN(par_en),
      .PARITY_ODD(par_odd), .DATA(data), .EN(en), .READY(ready), .IDLE(idle), .TX(tx)
   );

   uart_tx #(.STOP_BITS(2)) dut2 (
      .CLK(clk), .RESET_N(rst_n), .BIT_TIME(bit_time), .PARITY_EN(par_en),
      .PARITY_ODD(par_odd), .DATA(data), .EN(en2), .READY(ready2), .IDLE(idle2), .TX(tx2)
   );

   function automatic logic tx_of(input bit s);    return s ? tx2 : tx;       endfunction
   function automatic logic rdy_of(input bit s);   return s ? ready2 : ready; endfunction
   function automatic logic idle_of(input bit s);  return s ? idle2 : idle;   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Model: a frame is a list of line levels, each held for bt+1 cycles.
   task automatic push_frame(input logic [7:0] d, input int bt, input bit pe, input bit po, input int sb);
      bit b[$];
      b.push_back(1'b0);
      for (int i = 0; i < 8; i++) b.push_back(d[i]);
      if (pe) b.push_back(po ^ (^d));
      for (int i = 0; i < sb; i++) b.push_back(1'b1);
      foreach (b[i])
         for (int c = 0; c <= bt; c++) exp_q.push_back(b[i]);
   endtask

   // Returns at the falling edge right after the accepting edge.
   task automatic send(input bit s, input logic [7:0] d);
      @(negedge clk);
      chk("ready_before_write", rdy_of(s), 1);
      data = d;
      if (s) en2 = 1'b1; else en = 1'b1;
      @(negedge clk);
      en  = 1'b0;
      en2 = 1'b0;
      chk("ready_low_after_write", rdy_of(s), 0);
      chk("tx_idle_before_start", tx_of(s), 1);
   endtask

   task automatic check_stream(input bit s, input int from, input int to);
      for (int i = from; i < to; i++) begin
         @(negedge clk);
         chk($sformatf("tx[%0d]", i), tx_of(s), exp_q[i]);
         chk($sformatf("idle_busy[%0d]", i), idle_of(s), 0);
      end
   endtask

   task automatic check_end(input bit s);
      @(negedge clk);
      chk("idle_after_frame", idle_of(s), 1);
      chk("tx_after_frame", tx_of(s), 1);
      chk("ready_after_frame", rdy_of(s), 1);
   endtask

   initial begin
      logic [7:0] d;
      int         bt;
      bit         pe, po;

      bit_time = '0; par_en = 0; par_odd = 0; en = 0; en2 = 0; data = '0;
      repeat (3) @(negedge clk);
      chk("rst_tx", tx, 1);       chk("rst_ready", ready, 1);   chk("rst_idle", idle, 1);
      chk("rst_tx2", tx2, 1);     chk("rst_ready2", ready2, 1); chk("rst_idle2", idle2, 1);
      rst_n = 1'b1;

      // Plain frame, READY low for exactly one cycle
      bit_time = 16'd3;
      exp_q.delete(); push_frame(8'hA5, 3, 0, 0, 1);
      send(0, 8'hA5);
      check_stream(0, 0, 1);
      chk("ready_one_cycle", ready, 1);
      check_stream(0, 1, exp_q.size());
      check_end(0);

      // Even then odd parity on 0x07
      for (int p = 0; p < 2; p++) begin
         par_en = 1'b1; par_odd = p[0];
         exp_q.delete(); push_frame(8'h07, 3, 1, p[0], 1);
         send(0, 8'h07);
         check_stream(0, 0, exp_q.size());
         check_end(0);
      end

      // Back-to-back with dropped writes while the holding register is full
      par_en = 1'b0; bit_time = 16'd1;
      exp_q.delete(); push_frame(8'h11, 1, 0, 0, 1); push_frame(8'h22, 1, 0, 0, 1);
      send(0, 8'h11);
      data = 8'h22; en = 1'b1;
      check_stream(0, 0, 1);
      chk("dropped_write_ready", ready, 1);
      check_stream(0, 1, 2);
      en = 1'b0;
      chk("second_write_held", ready, 0);
      check_stream(0, 2, 5);
      data = 8'h33; en = 1'b1;
      check_stream(0, 5, 6);
      en = 1'b0;
      check_stream(0, 6, exp_q.size());
      check_end(0);

      // Two stop bits, one cycle per bit
      bit_time = 16'd0;
      exp_q.delete(); push_frame(8'h5A, 0, 0, 0, 2);
      send(1, 8'h5A);
      check_stream(1, 0, exp_q.size());
      check_end(1);

      // Write lands on the same edge as the stop-to-idle exit: one idle cycle, then start
      bit_time = 16'd1;
      exp_q.delete(); push_frame(8'h3C, 1, 0, 0, 1); exp_q.push_back(1'b1); push_frame(8'hC3, 1, 0, 0, 1);
      send(0, 8'h3C);
      check_stream(0, 0, 20);
      data = 8'hC3; en = 1'b1;
      check_stream(0, 20, 21);
      en = 1'b0;
      chk("edge_write_held", ready, 0);
      check_stream(0, 21, exp_q.size());
      check_end(0);

      // Reset during data bit 4 with a byte held
      bit_time = 16'd3;
      exp_q.delete(); push_frame(8'h2A, 3, 0, 0, 1);
      send(0, 8'h2A);
      check_stream(0, 0, 10);
      data = 8'hFF; en = 1'b1;
      check_stream(0, 10, 11);
      en = 1'b0;
      check_stream(0, 11, 22);
      chk("held_before_reset", ready, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_tx", tx, 1); chk("async_rst_ready", ready, 1); chk("async_rst_idle", idle, 1);
      @(negedge clk);
      rst_n = 1'b1;
      par_en = 1'b1; par_odd = 1'b1;
      exp_q.delete(); push_frame(8'hC9, 3, 1, 1, 1);
      send(0, 8'hC9);
      check_stream(0, 0, exp_q.size());
      check_end(0);

      // Random frames; settings are scrambled mid-frame and must not affect it
      for (int n = 0; n < 30; n++) begin
         bt = int'($urandom_range(0, 3));
         pe = 1'($urandom); po = 1'($urandom); d = 8'($urandom);
         bit_time = 16'(bt); par_en = pe; par_odd = po;
         exp_q.delete(); push_frame(d, bt, pe, po, 1);
         send(0, d);
         check_stream(0, 0, 1);
         bit_time = 16'($urandom_range(0, 15)); par_en = 1'($urandom); par_odd = 1'($urandom);
         check_stream(0, 1, exp_q.size());
         check_end(0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/uart_tx.md
# uart_tx

Serial UART transmitter, the transmit-side counterpart of the team's UART receiver, built to the same programmable bit time and parity settings. It accepts bytes through a one-entry holding register with a strobe/ready handshake and shifts them out LSB-first. Each frame is start bit, 8 data bits, optional parity bit and 1 or 2 stop bits. It sits between the CPU-side UART register block and the TX pin.

## Interface
- STOP_BITS, default 1: number of stop bits per frame; legal values are 1 and 2.

Ports:
- CLK, input, 1: system clock; every flop is rising-edge triggered.
- RESET_N, input, 1: reset, asynchronous and active-low.
- BIT_TIME, input, 16: bit period minus one, in CLK cycles. A bit lasts BIT_TIME+1 cycles, matching the receiver's count.
- PARITY_EN, input, 1: append a parity bit.
- PARITY_ODD, input, 1: 1 selects odd parity, 0 selects even.
- DATA, input, 8: byte to send; sampled when EN=1 and READY=1.
- EN, input, 1: single-cycle write strobe.
- READY, output, 1: holding register empty; a write is accepted this cycle.
- IDLE, output, 1: no frame in progress and holding register empty.
- TX, output, 1: serial line; idle-high, driven from a flop.

## Operation
- Reset values: TX=1, READY=1, IDLE=1, state ST_IDLE, holding register and shift register cleared, counters 0.
- Write rules:
  - EN & READY loads DATA into the holding register and clears READY.
  - EN while READY=0 is ignored. The byte is dropped and there is no error flag.
- FSM states and transitions:
  - ST_IDLE: go to ST_START when the holding register is full.
  - ST_START: go to ST_DATA after one bit period.
  - ST_DATA: stay for 8 bit periods, shifting right each period; at the end go to ST_PARITY if the latched PARITY_EN is 1, otherwise to ST_STOP.
  - ST_PARITY: go to ST_STOP after one bit period.
  - ST_STOP: stay for STOP_BITS bit periods, then go to ST_START if the holding register is full, otherwise to ST_IDLE.
- Entry to ST_START moves the holding register into the shift register and sets READY.
- BIT_TIME, PARITY_EN and PARITY_ODD are latched on entry to ST_START. Changes mid-frame take effect at the next frame.
- Parity bit = PARITY_ODD ^ (XOR of the 8 data bits). The receiver then reads a zero parity check.
- TX value per state: 0 in ST_START, shift register bit 0 in ST_DATA, parity bit in ST_PARITY, 1 in ST_STOP and ST_IDLE.
- Bit counter: 16 bits, counts 0..BIT_TIME, clears at the end of each bit period and never wraps past BIT_TIME. BIT_TIME=0 is legal and gives 1 cycle per bit.
- Data counter: 3 bits, counts data bits 0..7. The data phase ends when the count is 7 and the bit counter equals BIT_TIME.

## Timing
- Latency: if EN is accepted at edge k while IDLE=1, TX drives 0 from edge k+1.
- READY handshake for an isolated byte: READY is low for exactly the one cycle between edge k and edge k+1.
- Frame length = (BIT_TIME+1) × (9 + PARITY_EN + STOP_BITS) cycles. IDLE rises on the edge that ends the last stop bit.
- Back-to-back frames: if the holding register is full when the last stop bit ends, the next start bit begins on that same edge. There are no idle cycles between frames.
- Simultaneous events: EN arriving on the same edge as the ST_STOP→ST_IDLE exit is accepted. The FSM then passes through ST_IDLE for exactly one cycle before entering ST_START.
- RESET_N asserted mid-frame forces TX=1 and all outputs to their reset values immediately. The byte being sent and any held byte are lost.

## Structure
- Package uart_pkg holds:
  - the tx state enum tx_state_t, using the codebase's ST_ prefix;
  - the constant for legal STOP_BITS values.
- The receiver may move its own state enum into uart_pkg later.
- Sub-module uart_tx_fsm: the state register and next-state logic only.
- The uart_tx top level holds:
  - the bit and data counters;
  - the shift register;
  - the holding register;
  - the parity accumulator;
  - the TX output flop.
- All flops in this block reset asynchronously on RESET_N low. The existing synchronous-reset counter and ffd cells are not reused.

## Test plan
- BIT_TIME=3, parity off, write 0xA5 -> TX samples per 4-cycle bit are 0, then 1,0,1,0,0,1,0,1, then 1; IDLE returns after 40 cycles.
- BIT_TIME=3, parity on, even, write 0x07 -> parity bit 1. With odd parity, write 0x07 -> parity bit 0. Each frame is 44 cycles.
- Back-to-back: write 0x11, then write 0x22 while READY is low -> the second write is dropped. Write 0x22 again after READY rises -> its start bit immediately follows the stop bit of 0x11.
- STOP_BITS=2, BIT_TIME=0 -> frame is 11 cycles, TX=1 for the final 2 cycles.
- Pulse RESET_N low during data bit 4 -> TX=1 in the same cycle, READY=1, IDLE=1. A new write afterwards sends a clean frame.
- Loopback into the UART receiver with BIT_TIME=433, over 256 random bytes and all parity modes -> every byte is received intact and PARITY_ERR stays 0.
